// File: rtl/decoder_pkg.sv
// Shared mode encoding and one-hot/polarity helpers for decoder_n_scan.
// Helpers work at the widest supported size; callers narrow the result to their own OUT_W.
package decoder_pkg;

  localparam int unsigned MAX_SEL_W = 8;
  localparam int unsigned MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_SCAN   = 1'b1
  } mode_e;

  typedef logic [MAX_OUT_W-1:0] word_t;

  function automatic word_t onehot(input logic [MAX_SEL_W-1:0] idx);
    word_t w;
    w      = '0;
    w[idx] = 1'b1;
    return w;
  endfunction

  function automatic word_t apply_pol(input word_t word, input logic active_low);
    return active_low ? ~word : word;
  endfunction

endpackage

// File: rtl/decoder_scan_ctrl.sv
// Dwell counter and scan index sequencer for decoder_n_scan.
// Build option DECODER_PINGPONG_EN: bounce 0..OUT_W-1..0 instead of wrapping.
module decoder_scan_ctrl
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W   = 3,
  parameter int unsigned CNT_MAX = 24'd9_999_999
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             scan,
  input  logic             entry,
  output logic             step,
  output logic [SEL_W-1:0] idx,
  output logic [SEL_W-1:0] nxt_idx
);

  localparam int unsigned CW = (CNT_MAX == 0) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [SEL_W-1:0] IDX_LAST = '1;

  logic [CW-1:0] cnt;

  // Entry owns the cycle it occurs in, so a coincident wrap is suppressed.
  assign step = en && scan && !entry && (cnt == CW'(CNT_MAX));

`ifdef DECODER_PINGPONG_EN
  logic dir_down;
  logic dir_nxt;

  always_comb begin
    dir_nxt = dir_down;
    nxt_idx = idx + 1'b1;
    if (dir_down) begin
      if (idx == '0) begin
        dir_nxt = 1'b0;
        nxt_idx = idx + 1'b1;
      end else begin
        nxt_idx = idx - 1'b1;
      end
    end else if (idx == IDX_LAST) begin
      dir_nxt = 1'b1;
      nxt_idx = idx - 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      dir_down <= 1'b0;
    end else if (en) begin
      if (!scan || entry) begin
        dir_down <= 1'b0;
      end else if (step) begin
        dir_down <= dir_nxt;
      end
    end
  end
`else
  assign nxt_idx = idx + 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (en) begin
      if (!scan || entry) begin
        cnt <= '0;
        idx <= '0;
      end else if (step) begin
        cnt <= '0;
        idx <= nxt_idx;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered binary-to-one-hot decoder with enable and auto-scan mode.
// Build option DECODER_PINGPONG_EN selects a bouncing scan order (see decoder_scan_ctrl).
module decoder_n_scan
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned CNT_MAX    = 24'd9_999_999,
  parameter bit          ACTIVE_LOW = 1'b0,
  localparam int unsigned OUT_W     = 1 << SEL_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_valid,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic [SEL_W-1:0] scan_idx
);

  localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? '1 : '0;

  mode_e            mode_d;
  logic             en_d;
  logic             scanning;
  logic             entry;
  logic             step;
  logic [SEL_W-1:0] nxt_idx;

  function automatic logic [OUT_W-1:0] drive(input logic [SEL_W-1:0] idx);
    return OUT_W'(apply_pol(onehot(MAX_SEL_W'(idx)), ACTIVE_LOW));
  endfunction

  assign scanning = (mode_e'(mode) == MODE_SCAN);
  assign entry    = en && scanning && (mode_d == MODE_DIRECT);

  decoder_scan_ctrl #(
    .SEL_W   (SEL_W),
    .CNT_MAX (CNT_MAX)
  ) u_scan_ctrl (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .en        (en),
    .scan      (scanning),
    .entry     (entry),
    .step      (step),
    .idx       (scan_idx),
    .nxt_idx   (nxt_idx)
  );

  // mode_d only tracks while enabled, so a mode change made during en=0 is acted on at re-enable.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out       <= INACTIVE;
      out_valid <= 1'b0;
      mode_d    <= MODE_DIRECT;
      en_d      <= 1'b0;
    end else begin
      en_d <= en;
      if (!en) begin
        out       <= INACTIVE;
        out_valid <= 1'b0;
      end else begin
        mode_d <= mode_e'(mode);
        if (scanning) begin
          if (entry) begin
            out       <= drive('0);
            out_valid <= 1'b1;
          end else if (step) begin
            out       <= drive(nxt_idx);
            out_valid <= 1'b1;
          end else if (!en_d) begin
            out       <= drive(scan_idx);
            out_valid <= 1'b1;
          end else begin
            out_valid <= 1'b0;
          end
        end else if (in_valid) begin
          out       <= drive(in_sel);
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan: sequence-position model feeds an expected-word queue.
module tb_decoder_n_scan;

  localparam int unsigned OUT_W   = 8;
  localparam int unsigned CNT_MAX = 3;
`ifdef DECODER_PINGPONG_EN
  localparam int unsigned SEQ_L = 2 * OUT_W - 2;
`else
  localparam int unsigned SEQ_L = OUT_W;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic [2:0] in_sel = '0;
  logic [7:0] out;
  logic       out_valid;
  logic [2:0] scan_idx;

  logic        en2 = 1'b1, mode2 = 1'b0, in_valid2 = 1'b0;
  logic [3:0]  in_sel2 = '0;
  logic [15:0] out2;
  logic        out_valid2;
  logic [3:0]  scan_idx2;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] expq[$];
  int         seq[SEQ_L];
  bit         m_mprev, m_eprev, m_val;
  int         m_ticks, m_k;
  logic [7:0] m_out;
  logic [7:0] cur_out;
  logic       cur_val;
  logic [2:0] cur_idx;
  bit         chk_on = 1'b0;

  decoder_n_scan #(.SEL_W(3), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1'b0)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en), .mode(mode), .in_sel(in_sel),
    .in_valid(in_valid), .out(out), .out_valid(out_valid), .scan_idx(scan_idx)
  );

  decoder_n_scan #(.SEL_W(4), .CNT_MAX(CNT_MAX), .ACTIVE_LOW(1'b1)) dut_al (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en2), .mode(mode2), .in_sel(in_sel2),
    .in_valid(in_valid2), .out(out2), .out_valid(out_valid2), .scan_idx(scan_idx2)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic model_reset();
    m_mprev = 1'b0; m_eprev = 1'b0; m_val = 1'b0;
    m_ticks = 0; m_k = 0; m_out = '0;
    cur_out = '0; cur_val = 1'b0; cur_idx = '0;
    expq.delete();
  endtask

  // Scan position is an index into the visiting order; the dwell is a tick count.
  task automatic model_step();
    m_val = 1'b0;
    if (!en) begin
      m_out = '0;
    end else begin
      if (mode) begin
        if (!m_mprev) begin
          m_k = 0; m_ticks = 0; m_val = 1'b1;
        end else if (m_ticks == CNT_MAX) begin
          m_ticks = 0; m_k = (m_k + 1) % SEQ_L; m_val = 1'b1;
        end else begin
          m_ticks++;
          m_val = !m_eprev;
        end
        if (m_val) m_out = 8'h01 << seq[m_k];
      end else begin
        m_k = 0; m_ticks = 0;
        if (in_valid) begin
          m_out = 8'h01 << in_sel;
          m_val = 1'b1;
        end
      end
      m_mprev = mode;
    end
    m_eprev = en;
    if (m_val) expq.push_back(m_out);
  endtask

  task automatic cycle(input logic e, input logic m, input logic [2:0] s, input logic v);
    en = e; mode = m; in_sel = s; in_valid = v;
    model_step();
    @(posedge clk);
    cur_out = m_out; cur_val = m_val; cur_idx = 3'(seq[m_k]);
    #1;
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out !== 8'h00 || out_valid !== 1'b0 || scan_idx !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: out=%h valid=%b idx=%0d, required out=00 valid=0 idx=0",
               out, out_valid, scan_idx);
    end
    model_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_al(input string name, input logic [15:0] w, input logic v);
    n_vec++;
    if (out2 !== w || out_valid2 !== v || scan_idx2 !== 4'd0) begin
      n_err++;
      $display("FAIL %s: out=%h valid=%b idx=%0d, required out=%h valid=%b idx=0",
               name, out2, out_valid2, scan_idx2, w, v);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] w;
    if (chk_on) begin
      n_vec++;
      if (out !== cur_out || out_valid !== cur_val || scan_idx !== cur_idx) begin
        n_err++;
        $display("FAIL state t=%0t: out=%h valid=%b idx=%0d, required out=%h valid=%b idx=%0d",
                 $time, out, out_valid, scan_idx, cur_out, cur_val, cur_idx);
      end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL sb_pulse t=%0t: out_valid=1 out=%h, required no pulse", $time, out);
        end else begin
          w = expq.pop_front();
          if (out !== w) begin
            n_err++;
            $display("FAIL sb_word t=%0t: out=%h, required %h", $time, out, w);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < SEQ_L; i++) seq[i] = (i < OUT_W) ? i : (2 * OUT_W - 2 - i);

    #2;
    do_reset(3);
    chk_on = 1'b1;
    check_al("al_reset", 16'hFFFF, 1'b0);

    // Direct decode, hold, and active-low wide instance.
    in_sel2 = 4'd15; in_valid2 = 1'b1;
    cycle(1, 0, 3'd5, 1);
    check_al("al_sel15", 16'h7FFF, 1'b1);
    in_valid2 = 1'b0;
    repeat (3) cycle(1, 0, 3'd5, 0);
    check_al("al_hold", 16'h7FFF, 1'b0);
    in_sel2 = 4'd0; in_valid2 = 1'b1;
    cycle(1, 0, 3'd1, 1);
    check_al("al_sel0", 16'hFFFE, 1'b1);
    in_valid2 = 1'b0;
    cycle(1, 0, 3'd7, 1);
    cycle(1, 0, 3'd0, 1);
    repeat (2) cycle(0, 0, 3'd4, 1);
    repeat (2) cycle(1, 0, 3'd3, 0);

    // Full scan lap with inputs that must be ignored.
    repeat (40) cycle(1, 1, 3'($urandom), 1'($urandom));

    // Pause at idx 3, resume.
    for (int i = 0; i < 200 && seq[m_k] != 3; i++) cycle(1, 1, 3'd0, 0);
    repeat (10) cycle(0, 1, 3'd0, 0);
    repeat (8) cycle(1, 1, 3'd0, 0);

    // Exit at idx 6 with a simultaneous decode, then re-enter.
    for (int i = 0; i < 200 && seq[m_k] != 6; i++) cycle(1, 1, 3'd0, 0);
    cycle(1, 0, 3'd2, 1);
    repeat (2) cycle(1, 0, 3'd2, 0);
    repeat (6) cycle(1, 1, 3'd0, 0);

    // Reset mid-dwell at idx 4.
    for (int i = 0; i < 200 && seq[m_k] != 4; i++) cycle(1, 1, 3'd0, 0);
    cycle(1, 1, 3'd0, 0);
    mode = 1'b1;
    do_reset(2);
    repeat (10) cycle(1, 1, 3'd0, 0);

    begin
      logic rm;
      rm = 1'b0;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 39) == 0) rm = ~rm;
        cycle(($urandom_range(0, 15) != 0), rm, 3'($urandom), 1'($urandom));
      end
    end

    repeat (2) cycle(1, 0, 3'd0, 0);
    n_vec++;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain: %0d words pending, required 0", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
